// File: rtl/tt_um_hoene_pkg.sv
// rtl/tt_um_hoene_pkg.sv - shared state encoding and frame/timeout defaults
package tt_um_hoene_pkg;

  localparam int DEF_FRAME_BITS = 32;
  localparam int DEF_TIMEOUT    = 200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_FORWARD = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_um_hoene_gap_timer.sv
// rtl/tt_um_hoene_gap_timer.sv - saturating idle-gap counter with expiry look-ahead
module tt_um_hoene_gap_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  // Count idle cycles, restarting on clear and holding once LIMIT is reached.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Flags the cycle whose edge brings the count to LIMIT; a clear in the same
  // cycle masks it so a late strobe always defers the timeout.
  assign expired = enable && !clear && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/tt_um_hoene_protocol_frame_controller.sv
// rtl/tt_um_hoene_protocol_frame_controller.sv - LED frame own/forward controller (option: PARITY_CHECK_EN)
module tt_um_hoene_protocol_frame_controller
  import tt_um_hoene_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int TIMEOUT_W  = 8,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_clk,
  input  logic       in_data,
  input  logic       in_sync,
  input  logic       in_error,
  output logic [4:0] bit_counter,
  output logic [1:0] state,
  output logic       pwm_set,
  output logic       forward_en,
  output logic       error,
  output logic [7:0] frame_count
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_t     st_q, st_n;
  logic [4:0] bit_n;
  logic [7:0] fc_n;
  logic       pwm_n;
  logic       timeout;
  logic       link_bad;

  tt_um_hoene_gap_timer #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_clk),
    .enable  (1'b1),
    .expired (timeout)
  );

  assign link_bad = in_error || !in_sync;

`ifdef PARITY_CHECK_EN
  logic parity_q, parity_n;

  // Running XOR of the own-frame bits.
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_n;
  end
`else
  logic unused_data;
  assign unused_data = in_data;
`endif

  // Next-state, bit/frame counters and the one-shot frame-accept pulse.
  always_comb begin
    st_n  = st_q;
    bit_n = bit_counter;
    fc_n  = frame_count;
    pwm_n = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_n = parity_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (in_clk && in_sync && !in_error) begin
          st_n  = ST_OWN;
          bit_n = 5'd1;
`ifdef PARITY_CHECK_EN
          parity_n = in_data;
`endif
        end
      end
      ST_OWN: begin
        if (link_bad) begin
          st_n = ST_ERROR;
        end else if (timeout) begin
          st_n  = ST_IDLE;
          bit_n = 5'd0;
          fc_n  = 8'd0;
        end else if (in_clk) begin
`ifdef PARITY_CHECK_EN
          parity_n = parity_q ^ in_data;
`endif
          if (bit_counter == LAST_BIT) begin
            bit_n = 5'd0;
`ifdef PARITY_CHECK_EN
            if (parity_q ^ in_data) begin
              st_n = ST_ERROR;
            end else begin
              st_n  = ST_FORWARD;
              pwm_n = 1'b1;
            end
`else
            st_n  = ST_FORWARD;
            pwm_n = 1'b1;
`endif
          end else begin
            bit_n = bit_counter + 5'd1;
          end
        end
      end
      ST_FORWARD: begin
        if (link_bad) begin
          st_n = ST_ERROR;
        end else if (timeout) begin
          st_n  = ST_IDLE;
          bit_n = 5'd0;
          fc_n  = 8'd0;
        end else if (in_clk) begin
          if (bit_counter == LAST_BIT) begin
            bit_n = 5'd0;
            if (frame_count != 8'hFF) fc_n = frame_count + 8'd1;
          end else begin
            bit_n = bit_counter + 5'd1;
          end
        end
      end
      default: begin
        if (timeout) begin
          st_n  = ST_IDLE;
          bit_n = 5'd0;
          fc_n  = 8'd0;
        end
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      bit_counter <= 5'd0;
      frame_count <= 8'd0;
      pwm_set     <= 1'b0;
    end else begin
      st_q        <= st_n;
      bit_counter <= bit_n;
      frame_count <= fc_n;
      pwm_set     <= pwm_n;
    end
  end

  assign state      = st_q;
  assign forward_en = (st_q == ST_FORWARD);
  assign error      = (st_q == ST_ERROR);

endmodule

// File: tb/tb_tt_um_hoene_protocol_frame_controller.sv
// tb/tb_tt_um_hoene_protocol_frame_controller.sv - self-checking bench for the frame controller
module tb_tt_um_hoene_protocol_frame_controller;

  logic       clk = 1'b0;
  logic       rst, in_clk, in_data, in_sync, in_error;
  logic [4:0] bit_counter;
  logic [1:0] state;
  logic       pwm_set, forward_en, error;
  logic [7:0] frame_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pwm_seen = 0;
  int pwm_expected = 0;
  int exp_cyc;
  int exp_q[$];

  typedef struct {
    logic       ic, d, s, e;
    logic [1:0] st;
    logic [4:0] bc;
    logic       fwd, err;
  } vec_t;
  vec_t vecs[9];

  tt_um_hoene_protocol_frame_controller dut (
    .clk         (clk),
    .rst         (rst),
    .in_clk      (in_clk),
    .in_data     (in_data),
    .in_sync     (in_sync),
    .in_error    (in_error),
    .bit_counter (bit_counter),
    .state       (state),
    .pwm_set     (pwm_set),
    .forward_en  (forward_en),
    .error       (error),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Cycle index: value after an edge identifies that edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every pwm_set pulse must match a queued expected edge.
  always @(negedge clk) begin
    if (pwm_set === 1'b1) begin
      pwm_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pwm_unexpected: pulse at cycle %0d, none required", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (cyc != exp_cyc) begin
          bad++;
          $display("FAIL pwm_timing: pulse at cycle %0d, required at %0d", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic ic, input logic d, input logic s, input logic e);
    in_clk = ic; in_data = d; in_sync = s; in_error = e;
    @(posedge clk); #1;
    in_clk = 1'b0; in_error = 1'b0; in_sync = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic strobes(input int n, input logic d);
    for (int i = 0; i < n; i++) step(1'b1, d, 1'b1, 1'b0);
  endtask

  initial begin
    //          ic    d     s     e     st    bc     fwd   err
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 5'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 5'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 5'd3, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd3, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 5'd3, 1'b0, 1'b1};

    rst = 1'b1; in_clk = 1'b0; in_data = 1'b0; in_sync = 1'b1; in_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_bit", bit_counter, 0);
    check("rst_fc", frame_count, 0);
    check("rst_pwm", pwm_set, 0);
    check("rst_fwd", forward_en, 0);
    check("rst_err", error, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].ic, vecs[i].d, vecs[i].s, vecs[i].e);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_bit", i), bit_counter, vecs[i].bc);
      check($sformatf("vec%0d_fwd", i), forward_en, vecs[i].fwd);
      check($sformatf("vec%0d_err", i), error, vecs[i].err);
    end
    idle(199);
    check("err_hold_199", state, 3);
    idle(1);
    check("err_timeout_state", state, 0);
    check("err_timeout_bit", bit_counter, 0);

    for (int i = 0; i < 32; i++) begin
      step(1'b1, i[0], 1'b1, 1'b0);
      if (i == 0) check("own_enter", state, 1);
      if (i == 30) check("own_bit31", bit_counter, 31);
    end
    exp_q.push_back(cyc);
    pwm_expected++;
    check("fwd_state", state, 2);
    check("fwd_bit0", bit_counter, 0);
    check("fwd_en", forward_en, 1);
    strobes(64, 1'b1);
    check("fwd_fc2", frame_count, 2);
    strobes(255 * 32, 1'b0);
    check("fwd_fc_sat", frame_count, 255);
    idle(199);
    check("fwd_hold_199", state, 2);
    idle(1);
    check("fwd_timeout_state", state, 0);
    check("fwd_timeout_fc", frame_count, 0);
    check("fwd_timeout_en", forward_en, 0);

    strobes(10, 1'b0);
    check("own_bit10", bit_counter, 10);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("errhit_state", state, 3);
    check("errhit_bit", bit_counter, 10);
    idle(200);
    check("errhit_timeout", state, 0);

    strobes(20, 1'b1);
    idle(199);
    check("partial_hold", state, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("deferred_state", state, 1);
    check("deferred_bit", bit_counter, 21);
    idle(199);
    check("partial_hold2", state, 1);
    idle(1);
    check("partial_timeout_state", state, 0);
    check("partial_timeout_bit", bit_counter, 0);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    strobes(31, 1'b0);
`ifdef PARITY_CHECK_EN
    check("odd_parity_state", state, 3);
    check("odd_parity_err", error, 1);
`else
    exp_q.push_back(cyc);
    pwm_expected++;
    check("odd_parity_state", state, 2);
`endif
    idle(200);
    check("odd_parity_timeout", state, 0);

    strobes(31, 1'b0);
    check("pre_rst_bit", bit_counter, 31);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_bit", bit_counter, 0);
    check("midrst_pwm", pwm_set, 0);
    check("midrst_fwd", forward_en, 0);
    check("midrst_err", error, 0);
    check("midrst_fc", frame_count, 0);
    idle(3);

    check("pwm_pending", exp_q.size(), 0);
    check("pwm_count", pwm_seen, pwm_expected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_protocol_frame_controller.md
TT_UM_HOENE_PROTOCOL_FRAME_CONTROLLER -- requirements
Module: tt_um_hoene_protocol_frame_controller

Interface
REQ-001 Parameter FRAME_BITS, default 32, SHALL set the number of bits per LED frame.
REQ-002 Parameter TIMEOUT_W, default 8, SHALL set the width of the idle-gap counter.
REQ-003 Parameter TIMEOUT, default 200, SHALL set the number of clk cycles without in_clk that ends a frame sequence (latch gap).
REQ-004 Port clk, input, 1 bit, SHALL be the single system clock; all logic is sampled on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-006 Port in_clk, input, 1 bit, SHALL be the decoded-bit strobe, a one-cycle pulse in the clk domain.
REQ-007 Port in_data, input, 1 bit, SHALL be the decoded bit value, valid when in_clk=1.
REQ-008 Port in_sync, input, 1 bit, SHALL be the decoder lock indication.
REQ-009 Port in_error, input, 1 bit, SHALL be the decoder error indication.
REQ-010 Port bit_counter, output, 5 bits, SHALL be the bit index within the current frame, 0..FRAME_BITS-1.
REQ-011 Port state, output, 2 bits, SHALL encode IDLE=0, OWN=1, FORWARD=2, ERROR=3.
REQ-012 Port pwm_set, output, 1 bit, SHALL pulse for one cycle when the own frame is complete and accepted.
REQ-013 Port forward_en, output, 1 bit, SHALL enable the downstream encoder.
REQ-014 Port error, output, 1 bit, SHALL be high while state=ERROR.
REQ-015 Port frame_count, output, 8 bits, SHALL be the saturating count of forwarded frames since IDLE.

Function
REQ-016 IDLE: on in_clk=1 with in_sync=1 and in_error=0 the block SHALL go to OWN with bit_counter=1 (bit 0 consumed).
REQ-017 OWN: each in_clk SHALL increment bit_counter; the in_clk at bit_counter=FRAME_BITS-1 SHALL wrap bit_counter to 0, move to FORWARD, and assert pwm_set in the next cycle.
REQ-018 FORWARD: forward_en SHALL be 1; bit_counter SHALL count modulo FRAME_BITS; each wrap SHALL increment frame_count, saturating at 255.
REQ-019 In OWN or FORWARD, in_error=1 or in_sync=0 SHALL force ERROR next cycle; an in_clk in the same cycle SHALL NOT be counted (error wins).
REQ-020 The idle counter SHALL clear on every in_clk and otherwise increment, saturating at TIMEOUT; on reaching TIMEOUT in any state other than IDLE the block SHALL go to IDLE and clear bit_counter and frame_count.
REQ-021 When in_clk and timeout occur in the same cycle, in_clk SHALL win and the timeout SHALL be ignored.
REQ-022 A timeout in OWN SHALL discard the partial frame, with no pwm_set.
REQ-023 ERROR SHALL be left only via timeout to IDLE; in_clk in ERROR SHALL be ignored apart from clearing the idle counter.
REQ-024 forward_en SHALL be 0 in IDLE, OWN and ERROR; pwm_set SHALL never assert outside the OWN->FORWARD transition.

Reset
REQ-025 rst=1 SHALL set state=IDLE and clear bit_counter, frame_count, the idle counter, pwm_set, forward_en, error and the parity accumulator.
REQ-026 Reset mid-frame SHALL take effect on the next clk edge, with no pwm_set emitted.

Configuration
REQ-027 With PARITY_CHECK_EN defined, the block SHALL accumulate the XOR of all own-frame bits; odd parity at frame end SHALL suppress pwm_set and move to ERROR instead of FORWARD.
REQ-028 Without PARITY_CHECK_EN, no parity logic SHALL exist and every complete own frame SHALL produce pwm_set.

Structure
REQ-029 A shared package SHALL hold the state encoding and the FRAME_BITS/TIMEOUT defaults, for reuse by the select and serial2parallel blocks.
REQ-030 The idle-gap counter SHALL be a sub-module named tt_um_hoene_gap_timer (inputs clear/enable, output expired).

Verification
REQ-031 Reset, then 32 in_clk pulses with in_sync=1 and even-parity data -> state 0->1->2, pwm_set exactly once, one cycle after the 32nd strobe.
REQ-032 64 further strobes after the own frame -> forward_en=1 and frame_count=2; then 200 idle cycles -> state=0 and frame_count=0.
REQ-033 in_error=1 at bit 10 of the own frame, coincident with in_clk -> state=3, bit_counter stays 10, no pwm_set; after 200 idle cycles -> state=0.
REQ-034 Own frame stopped after 20 strobes, then 200 idle cycles -> state=0 with no pwm_set; in_clk at idle count 199 -> timeout deferred.
REQ-035 PARITY_CHECK_EN defined and a frame with odd parity -> state=3 and no pwm_set; the same frame without the macro -> pwm_set=1.
REQ-036 rst=1 asserted at bit 31 of the own frame -> all outputs 0 on the next cycle and no pwm_set.
